// File: rtl/phys_mem_ctrl.sv
// Purpose: decode mmu word accesses to async SRAM, UART MMIO or unmapped space; run SRAM strobe timing and UART byte handshake.
// Latency: SRAM read WAIT_CYCLES+2, SRAM write WAIT_CYCLES+4, UART/unmapped 1 cycle (busy-low cycle counted from first request cycle).
// Backpressure: dev_mem_busy held high until completion; UART tx write stalls indefinitely while uart_tx_ready=0.
module phys_mem_ctrl #(
    parameter int          SRAM_AW     = 20,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] UART_DATA   = 32'h1FD003F8,
    parameter logic [31:0] UART_STAT   = 32'h1FD003FC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        dev_mem_addr,
    input  logic [31:0]        dev_mem_data_out,
    input  logic               dev_mem_is_write,
    output logic [31:0]        dev_mem_data_in,
    output logic               dev_mem_busy,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [31:0]        sram_dq_i,
    output logic [31:0]        sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [7:0]         uart_tx_data,
    output logic               uart_tx_valid,
    input  logic               uart_tx_ready,
    input  logic [7:0]         uart_rx_data,
    input  logic               uart_rx_valid,
    output logic               uart_rx_ack
);

    localparam logic [32:0] RAM_END = 33'd4 << SRAM_AW;
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_TX_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] req_addr_q, req_addr_d;
    logic        req_we_q, req_we_d;
    logic [31:0] req_data_q, req_data_d;
    logic        last_valid_q, last_valid_d;
    logic [29:0] last_addr_q, last_addr_d;
    logic        last_we_q, last_we_d;
    logic [31:0] last_data_q, last_data_d;
    logic [31:0] data_in_q, data_in_d;
    logic        rx_ack_q, rx_ack_d;

    logic hit, done, is_ram, is_data, is_stat;

    // Request matching and address decode on the live bus
    always_comb begin
        hit = last_valid_q
            && (dev_mem_addr[31:2] == last_addr_q)
            && (dev_mem_is_write == last_we_q)
            && (!dev_mem_is_write || (dev_mem_data_out == last_data_q));
        is_ram  = ({1'b0, dev_mem_addr} < RAM_END);
        is_data = (dev_mem_addr[31:2] == UART_DATA[31:2]);
        is_stat = (dev_mem_addr[31:2] == UART_STAT[31:2]);
    end

    // Next-state logic: access sequencing, completion and last-request tracking
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_addr_d   = req_addr_q;
        req_we_d     = req_we_q;
        req_data_d   = req_data_q;
        last_valid_d = last_valid_q;
        last_addr_d  = last_addr_q;
        last_we_d    = last_we_q;
        last_data_d  = last_data_q;
        data_in_d    = data_in_q;
        rx_ack_d     = 1'b0;
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    req_addr_d = dev_mem_addr[31:2];
                    req_we_d   = dev_mem_is_write;
                    req_data_d = dev_mem_data_out;
                    if (is_ram) begin
                        state_d = dev_mem_is_write ? S_WR_SETUP : S_RD;
                        cnt_d   = WAIT_L;
                    end else if (is_data && dev_mem_is_write) begin
                        state_d = S_TX_WAIT;
                    end else begin
                        // UART register reads and unmapped accesses finish in this cycle
                        done = 1'b1;
                        if (!dev_mem_is_write) begin
                            if (is_data) begin
                                data_in_d = uart_rx_valid ? {24'b0, uart_rx_data} : 32'b0;
                                rx_ack_d  = uart_rx_valid;
                            end else if (is_stat) begin
                                data_in_d = {30'b0, uart_rx_valid, uart_tx_ready};
                            end else begin
                                data_in_d = 32'b0;
                            end
                        end
                    end
                end else if (last_we_q) begin
                    // a write completes once: after its busy-low cycle it no longer matches
                    last_valid_d = 1'b0;
                end
            end
            S_RD: begin
                if (cnt_q == 4'd0) begin
                    data_in_d = sram_dq_i;
                    done      = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = WAIT_L;
            end
            S_WR_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WR_HOLD: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_TX_WAIT: begin
                if (uart_tx_ready) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (done) begin
            last_valid_d = 1'b1;
            last_addr_d  = req_addr_d;
            last_we_d    = req_we_d;
            last_data_d  = req_data_d;
        end
    end

    // State and request registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            req_addr_q   <= 30'b0;
            req_we_q     <= 1'b0;
            req_data_q   <= 32'b0;
            last_valid_q <= 1'b0;
            last_addr_q  <= 30'b0;
            last_we_q    <= 1'b0;
            last_data_q  <= 32'b0;
            data_in_q    <= 32'b0;
            rx_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_addr_q   <= req_addr_d;
            req_we_q     <= req_we_d;
            req_data_q   <= req_data_d;
            last_valid_q <= last_valid_d;
            last_addr_q  <= last_addr_d;
            last_we_q    <= last_we_d;
            last_data_q  <= last_data_d;
            data_in_q    <= data_in_d;
            rx_ack_q     <= rx_ack_d;
        end
    end

    // Strobes decode straight from state so reset releases them immediately
    always_comb begin
        sram_ce_n     = !((state_q == S_RD) || (state_q == S_WR_SETUP) ||
                          (state_q == S_WR_PULSE) || (state_q == S_WR_HOLD));
        sram_oe_n     = (state_q != S_RD);
        sram_we_n     = (state_q != S_WR_PULSE);
        sram_dq_oe    = (state_q == S_WR_SETUP) || (state_q == S_WR_PULSE) ||
                        (state_q == S_WR_HOLD);
        sram_addr     = req_addr_q[SRAM_AW-1:0];
        sram_dq_o     = req_data_q;
        uart_tx_valid = (state_q == S_TX_WAIT);
        uart_tx_data  = req_data_q[7:0];
        uart_rx_ack   = rx_ack_q;
        dev_mem_data_in = data_in_q;
        dev_mem_busy  = (state_q != S_IDLE) || !hit;
    end

endmodule
